// File: rtl/vga_pkg.sv
// Shared types, timing helpers and the colour-bar table for the VGA timing generator.
package vga_pkg;

   typedef enum logic {StRun, StPending} mode_st_e;

   localparam logic MODE_PASS = 1'b0;
   localparam logic MODE_BARS = 1'b1;

   function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int unsigned calc_sync_start(input int unsigned act,
                                                   input int unsigned fp);
      return act + fp;
   endfunction

   function automatic int unsigned calc_sync_end(input int unsigned act, input int unsigned fp,
                                                 input int unsigned sync);
      return act + fp + sync;
   endfunction

   // Default 640x480@60 figures.
   localparam int unsigned H_TOTAL      = calc_total(640, 16, 96, 48);
   localparam int unsigned V_TOTAL      = calc_total(480, 10, 2, 33);
   localparam int unsigned H_SYNC_START = calc_sync_start(640, 16);
   localparam int unsigned H_SYNC_END   = calc_sync_end(640, 16, 96);
   localparam int unsigned V_SYNC_START = calc_sync_start(480, 10);
   localparam int unsigned V_SYNC_END   = calc_sync_end(480, 10, 2);

   // {r,g,b}: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [0:7][2:0] BAR_RGB = {3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   function automatic logic [2:0] bar_colour(input logic [2:0] k);
      return BAR_RGB[k];
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with sync-window and active-region decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [CNT_W-1:0] total_i,
   input  logic [CNT_W-1:0] sync_start_i,
   input  logic [CNT_W-1:0] sync_end_i,
   input  logic [CNT_W-1:0] active_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             wrap_o,
   output logic             in_sync_o,
   output logic             in_active_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_end;

   assign at_end = (cnt_q == total_i - CNT_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign wrap_o      = en_i & at_end;
   assign in_sync_o   = (cnt_q >= sync_start_i) && (cnt_q < sync_end_i);
   assign in_active_o = (cnt_q < active_i);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with pass-through or colour-bar RGB output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned NUM_BARS = 8,
   parameter int unsigned CNT_W    = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode_req,
   input  logic [3*COLOR_W-1:0] rgb_in,
   output logic                 pix_en,
   output logic [CNT_W-1:0]     pix_x,
   output logic [CNT_W-1:0]     pix_y,
   output logic                 active,
   output logic                 line_start,
   output logic                 frame_start,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 mode_cur
);

   localparam int unsigned HTotal     = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned VTotal     = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HSyncStart = calc_sync_start(H_ACTIVE, H_FP);
   localparam int unsigned HSyncEnd   = calc_sync_end(H_ACTIVE, H_FP, H_SYNC);
   localparam int unsigned VSyncStart = calc_sync_start(V_ACTIVE, V_FP);
   localparam int unsigned VSyncEnd   = calc_sync_end(V_ACTIVE, V_FP, V_SYNC);
   localparam int unsigned BarW       = H_ACTIVE / NUM_BARS;

   logic [7:0]           div_q, div_d;
   logic [CNT_W-1:0]     h_cnt, v_cnt;
   logic                 h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
   mode_st_e             st_q, st_d;
   logic                 mode_q, mode_d;
   logic                 hs_q, hs_d, vs_q, vs_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;
   logic [2:0]           bar_sel, bar_bits;

   assign pix_en = (div_q == 8'(CLK_DIV - 1));
   assign div_d  = pix_en ? 8'd0 : div_q + 8'd1;

   vga_axis_counter #(.CNT_W(CNT_W)) u_h_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (pix_en),
      .total_i      (CNT_W'(HTotal)),
      .sync_start_i (CNT_W'(HSyncStart)),
      .sync_end_i   (CNT_W'(HSyncEnd)),
      .active_i     (CNT_W'(H_ACTIVE)),
      .cnt_o        (h_cnt),
      .wrap_o       (h_wrap),
      .in_sync_o    (h_sync),
      .in_active_o  (h_act)
   );

   vga_axis_counter #(.CNT_W(CNT_W)) u_v_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (h_wrap),
      .total_i      (CNT_W'(VTotal)),
      .sync_start_i (CNT_W'(VSyncStart)),
      .sync_end_i   (CNT_W'(VSyncEnd)),
      .active_i     (CNT_W'(V_ACTIVE)),
      .cnt_o        (v_cnt),
      .wrap_o       (v_wrap),
      .in_sync_o    (v_sync),
      .in_active_o  (v_act)
   );

   assign pix_x       = h_cnt;
   assign pix_y       = v_cnt;
   assign active      = h_act & v_act;
   assign line_start  = pix_en & (h_cnt == '0);
   assign frame_start = line_start & (v_cnt == '0);

   // Mode switches only at frame_start so a frame is never torn between sources.
   always_comb begin
      st_d   = st_q;
      mode_d = mode_q;
      case (st_q)
         StRun: begin
            if (mode_req != mode_q) st_d = StPending;
         end
         StPending: begin
            if (mode_req == mode_q) begin
               st_d = StRun;
            end else if (frame_start) begin
               mode_d = mode_req;
               st_d   = StRun;
            end
         end
         default: st_d = StRun;
      endcase
   end

   assign bar_sel  = 3'(h_cnt / CNT_W'(BarW));
   assign bar_bits = bar_colour(bar_sel);

   // mode_d is used so the pixel at frame_start already carries the new mode.
   always_comb begin
      hs_d  = hs_q;
      vs_d  = vs_q;
      rgb_d = rgb_q;
      if (pix_en) begin
         hs_d = h_sync ? HS_POL : ~HS_POL;
         vs_d = v_sync ? VS_POL : ~VS_POL;
         if (!active) begin
            rgb_d = '0;
         end else if (mode_d == MODE_BARS) begin
            rgb_d = {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}}, {COLOR_W{bar_bits[0]}}};
         end else begin
            rgb_d = rgb_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         st_q   <= StRun;
         mode_q <= MODE_PASS;
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         rgb_q  <= '0;
      end else begin
         div_q  <= div_d;
         st_q   <= st_d;
         mode_q <= mode_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         rgb_q  <= rgb_d;
      end
   end

   assign vga_hs   = hs_q;
   assign vga_vs   = vs_q;
   assign vga_r    = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign vga_g    = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign vga_b    = rgb_q[COLOR_W-1:0];
   assign mode_cur = mode_q;

endmodule
